// File: rtl/jk_ff_bank_if.sv
// rtl/jk_ff_bank_if.sv - control/data bundle for the JK flip-flop bank
interface jk_ff_bank_if #(
   parameter int WIDTH = 8
);
   logic             en;
   logic [1:0]       mode;
   logic [WIDTH-1:0] bit_en;
   logic [WIDTH-1:0] j;
   logic [WIDTH-1:0] k;
   logic [WIDTH-1:0] d;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qb;
   logic [WIDTH-1:0] changed;
   logic             wrap;

   modport master (
      output en, mode, bit_en, j, k, d,
      input  q, qb, changed, wrap
   );

   modport slave (
      input  en, mode, bit_en, j, k, d,
      output q, qb, changed, wrap
   );
endinterface

// File: rtl/jk_ff_bank.sv
// rtl/jk_ff_bank.sv - bank of JK flip-flops with load and up/down count modes
module jk_ff_bank #(
   parameter int               WIDTH   = 8,
   parameter logic [WIDTH-1:0] RST_VAL = {WIDTH{1'b0}}
) (
   input  logic          clk,
   input  logic          rst,
   jk_ff_bank_if.slave   bus
);
   localparam logic [1:0] MODE_JK   = 2'b00;
   localparam logic [1:0] MODE_LOAD = 2'b01;

   logic [WIDTH-1:0] q_r;
   logic [WIDTH-1:0] changed_r;
   logic             wrap_r;

   logic [WIDTH-1:0] t;
   logic [WIDTH-1:0] jv;
   logic [WIDTH-1:0] kv;
   logic [WIDTH-1:0] q_next;
   logic             wrap_next;

   // Every mode is reduced to per-bit J/K terms feeding one JK next-state equation.
   always_comb begin
      t         = '0;
      jv        = '0;
      kv        = '0;
      wrap_next = 1'b0;
      t[0]      = 1'b1;
      for (int i = 1; i < WIDTH; i++) begin
         t[i] = t[i-1] & (bus.mode[0] ? ~q_r[i-1] : q_r[i-1]);
      end
      case (bus.mode)
         MODE_JK: begin
            jv = bus.j & bus.bit_en;
            kv = bus.k & bus.bit_en;
         end
         MODE_LOAD: begin
            jv = bus.d & bus.bit_en;
            kv = ~bus.d & bus.bit_en;
         end
         default: begin
            jv = t;
            kv = t;
            // A single-bit counter flags wrap on every count edge.
            wrap_next = (WIDTH == 1) ? 1'b1
                      : t[WIDTH-1] & (bus.mode[0] ? ~q_r[WIDTH-1] : q_r[WIDTH-1]);
         end
      endcase
      q_next = (jv & ~q_r) | (~kv & q_r);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         q_r       <= RST_VAL;
         changed_r <= '0;
         wrap_r    <= 1'b0;
      end else if (!bus.en) begin
         changed_r <= '0;
         wrap_r    <= 1'b0;
      end else begin
         q_r       <= q_next;
         changed_r <= q_r ^ q_next;
         wrap_r    <= wrap_next;
      end
   end

   assign bus.q       = q_r;
   assign bus.qb      = ~q_r;
   assign bus.changed = changed_r;
   assign bus.wrap    = wrap_r;
endmodule

// File: tb/tb_jk_ff_bank.sv
// tb/tb_jk_ff_bank.sv - directed-vector bench for jk_ff_bank at WIDTH 8, 1 and 32
module tb_jk_ff_bank;
   logic clk;
   logic rst;
   int   n_cmp;
   int   n_fail;

   jk_ff_bank_if #(.WIDTH(8))  b8 ();
   jk_ff_bank_if #(.WIDTH(1))  b1 ();
   jk_ff_bank_if #(.WIDTH(32)) b32 ();

   jk_ff_bank #(.WIDTH(8), .RST_VAL(8'hA5)) dut8 (.clk(clk), .rst(rst), .bus(b8));
   jk_ff_bank #(.WIDTH(1))                  dut1 (.clk(clk), .rst(rst), .bus(b1));
   jk_ff_bank #(.WIDTH(32))                 dut32 (.clk(clk), .rst(rst), .bus(b32));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic load8(input logic [7:0] v);
      b8.en = 1'b1; b8.mode = 2'b01; b8.bit_en = 8'hFF; b8.d = v;
      tick();
   endtask

   task automatic test_reset;
      rst = 1'b0; b8.en = 1'b1; b8.mode = 2'b10;
      for (int e = 0; e < 2; e++) begin
         tick();
         if (b8.q !== 8'hA5) begin n_fail++; $display("FAIL reset_q got=%h exp=a5", b8.q); end
         n_cmp++;
         if (b8.qb !== 8'h5A) begin n_fail++; $display("FAIL reset_qb got=%h exp=5a", b8.qb); end
         n_cmp++;
         if (b8.changed !== 8'h00) begin n_fail++; $display("FAIL reset_changed got=%h exp=00", b8.changed); end
         n_cmp++;
         if (b8.wrap !== 1'b0) begin n_fail++; $display("FAIL reset_wrap got=%b exp=0", b8.wrap); end
         n_cmp++;
      end
      if (b1.q !== 1'b0 || b32.q !== 32'h0) begin
         n_fail++; $display("FAIL reset_small got=%b/%h exp=0/0", b1.q, b32.q);
      end
      n_cmp++;
      rst = 1'b1;
      load8(8'h03);
      if (b8.changed !== 8'hA6) begin n_fail++; $display("FAIL load03_changed got=%h exp=a6", b8.changed); end
      n_cmp++;
      b8.mode = 2'b10;
      tick();
      if (b8.q !== 8'h04) begin n_fail++; $display("FAIL count_before_abort got=%h exp=04", b8.q); end
      n_cmp++;
      rst = 1'b0;
      tick();
      if (b8.q !== 8'hA5 || b8.changed !== 8'h00 || b8.wrap !== 1'b0) begin
         n_fail++; $display("FAIL reset_mid_count q=%h ch=%h w=%b exp=a5/00/0", b8.q, b8.changed, b8.wrap);
      end
      n_cmp++;
      rst = 1'b1;
   endtask

   task automatic test_jk;
      load8(8'h00);
      b8.mode = 2'b00; b8.bit_en = 8'hFF; b8.j = 8'hF0; b8.k = 8'h0C;
      tick();
      if (b8.q !== 8'hF0 || b8.changed !== 8'hF0) begin
         n_fail++; $display("FAIL jk_set_reset q=%h ch=%h exp=f0/f0", b8.q, b8.changed);
      end
      n_cmp++;
      b8.j = 8'hFF; b8.k = 8'hFF;
      tick();
      if (b8.q !== 8'h0F || b8.changed !== 8'hFF) begin
         n_fail++; $display("FAIL jk_toggle q=%h ch=%h exp=0f/ff", b8.q, b8.changed);
      end
      n_cmp++;
      if (b8.qb !== 8'hF0) begin n_fail++; $display("FAIL jk_qb got=%h exp=f0", b8.qb); end
      n_cmp++;
      b8.j = 8'h00; b8.k = 8'h00;
      tick();
      if (b8.q !== 8'h0F || b8.changed !== 8'h00 || b8.wrap !== 1'b0) begin
         n_fail++; $display("FAIL jk_hold q=%h ch=%h w=%b exp=0f/00/0", b8.q, b8.changed, b8.wrap);
      end
      n_cmp++;
   endtask

   task automatic test_bit_en;
      b8.mode = 2'b00; b8.j = 8'hFF; b8.k = 8'hFF; b8.bit_en = 8'h81;
      tick();
      if (b8.q !== 8'h8E || b8.changed !== 8'h81) begin
         n_fail++; $display("FAIL bit_en_jk q=%h ch=%h exp=8e/81", b8.q, b8.changed);
      end
      n_cmp++;
      b8.mode = 2'b01; b8.d = 8'h55; b8.bit_en = 8'hF0;
      tick();
      if (b8.q !== 8'h5E || b8.changed !== 8'hD0) begin
         n_fail++; $display("FAIL bit_en_load q=%h ch=%h exp=5e/d0", b8.q, b8.changed);
      end
      n_cmp++;
   endtask

   task automatic test_count_up;
      logic [7:0] exp_q [3];
      logic [7:0] exp_c [3];
      logic       exp_w [3];
      exp_q = '{8'hFF, 8'h00, 8'h01};
      exp_c = '{8'h01, 8'hFF, 8'h01};
      exp_w = '{1'b0, 1'b1, 1'b0};
      load8(8'hFE);
      b8.mode = 2'b10; b8.bit_en = 8'h00; b8.j = 8'hFF; b8.k = 8'h00;
      for (int e = 0; e < 3; e++) begin
         tick();
         if (b8.q !== exp_q[e] || b8.changed !== exp_c[e] || b8.wrap !== exp_w[e]) begin
            n_fail++;
            $display("FAIL count_up[%0d] q=%h ch=%h w=%b exp=%h/%h/%b",
                     e, b8.q, b8.changed, b8.wrap, exp_q[e], exp_c[e], exp_w[e]);
         end
         n_cmp++;
      end
   endtask

   task automatic test_count_down;
      load8(8'h01);
      b8.mode = 2'b11;
      tick();
      if (b8.q !== 8'h00 || b8.wrap !== 1'b0) begin
         n_fail++; $display("FAIL count_down_0 q=%h w=%b exp=00/0", b8.q, b8.wrap);
      end
      n_cmp++;
      tick();
      if (b8.q !== 8'hFF || b8.changed !== 8'hFF || b8.wrap !== 1'b1) begin
         n_fail++; $display("FAIL count_down_wrap q=%h ch=%h w=%b exp=ff/ff/1", b8.q, b8.changed, b8.wrap);
      end
      n_cmp++;
      b8.en = 1'b0;
      for (int e = 0; e < 3; e++) begin
         tick();
         if (b8.q !== 8'hFF || b8.changed !== 8'h00 || b8.wrap !== 1'b0) begin
            n_fail++; $display("FAIL en_hold[%0d] q=%h ch=%h w=%b exp=ff/00/0", e, b8.q, b8.changed, b8.wrap);
         end
         n_cmp++;
      end
      b8.en = 1'b1;
   endtask

   task automatic test_back_to_back;
      b8.mode = 2'b10;
      tick();
      if (b8.q !== 8'h00 || b8.wrap !== 1'b1) begin
         n_fail++; $display("FAIL b2b_up q=%h w=%b exp=00/1", b8.q, b8.wrap);
      end
      n_cmp++;
      b8.mode = 2'b11;
      tick();
      if (b8.q !== 8'hFF || b8.wrap !== 1'b1) begin
         n_fail++; $display("FAIL b2b_down q=%h w=%b exp=ff/1", b8.q, b8.wrap);
      end
      n_cmp++;
      b8.mode = 2'b00; b8.bit_en = 8'h03; b8.j = 8'h00; b8.k = 8'h02;
      tick();
      if (b8.q !== 8'hFD || b8.changed !== 8'h02 || b8.wrap !== 1'b0) begin
         n_fail++; $display("FAIL b2b_jk q=%h ch=%h w=%b exp=fd/02/0", b8.q, b8.changed, b8.wrap);
      end
      n_cmp++;
      b8.mode = 2'b11;
      tick();
      if (b8.q !== 8'hFC || b8.changed !== 8'h01) begin
         n_fail++; $display("FAIL b2b_down_from_jk q=%h ch=%h exp=fc/01", b8.q, b8.changed);
      end
      n_cmp++;
   endtask

   task automatic test_width_sweep;
      logic       exp1_q [4];
      logic [1:0] m1 [4];
      m1     = '{2'b10, 2'b10, 2'b11, 2'b11};
      exp1_q = '{1'b0, 1'b1, 1'b0, 1'b1};
      b8.en = 1'b0;
      b1.en = 1'b1; b1.mode = 2'b01; b1.bit_en = 1'b1; b1.d = 1'b1; b1.j = 1'b0; b1.k = 1'b0;
      b32.en = 1'b1; b32.mode = 2'b01; b32.bit_en = 32'hFFFF_FFFF; b32.d = 32'hFFFF_FFFF;
      b32.j = 32'h0; b32.k = 32'h0;
      tick();
      if (b1.q !== 1'b1 || b32.q !== 32'hFFFF_FFFF) begin
         n_fail++; $display("FAIL sweep_load q1=%b q32=%h exp=1/ffffffff", b1.q, b32.q);
      end
      n_cmp++;
      b32.mode = 2'b10;
      for (int e = 0; e < 4; e++) begin
         b1.mode = m1[e];
         tick();
         if (b1.q !== exp1_q[e] || b1.wrap !== 1'b1 || b1.changed !== 1'b1) begin
            n_fail++;
            $display("FAIL w1_count[%0d] q=%b w=%b ch=%b exp=%b/1/1", e, b1.q, b1.wrap, b1.changed, exp1_q[e]);
         end
         n_cmp++;
         if (e == 0) begin
            if (b32.q !== 32'h0 || b32.wrap !== 1'b1 || b32.changed !== 32'hFFFF_FFFF) begin
               n_fail++; $display("FAIL w32_up_wrap q=%h w=%b ch=%h exp=0/1/ffffffff", b32.q, b32.wrap, b32.changed);
            end
            n_cmp++;
            b32.mode = 2'b11;
         end else if (e == 1) begin
            if (b32.q !== 32'hFFFF_FFFF || b32.wrap !== 1'b1) begin
               n_fail++; $display("FAIL w32_down_wrap q=%h w=%b exp=ffffffff/1", b32.q, b32.wrap);
            end
            n_cmp++;
         end else if (e == 2) begin
            if (b32.q !== 32'hFFFF_FFFE || b32.wrap !== 1'b0) begin
               n_fail++; $display("FAIL w32_down q=%h w=%b exp=fffffffe/0", b32.q, b32.wrap);
            end
            n_cmp++;
         end
      end
   endtask

   initial begin
      n_cmp = 0; n_fail = 0;
      rst = 1'b0;
      b8.en = 1'b0; b8.mode = 2'b00; b8.bit_en = '0; b8.j = '0; b8.k = '0; b8.d = '0;
      b1.en = 1'b0; b1.mode = 2'b00; b1.bit_en = '0; b1.j = '0; b1.k = '0; b1.d = '0;
      b32.en = 1'b0; b32.mode = 2'b00; b32.bit_en = '0; b32.j = '0; b32.k = '0; b32.d = '0;
      test_reset();
      test_jk();
      test_bit_en();
      test_count_up();
      test_count_down();
      test_back_to_back();
      test_width_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule

// File: doc/jk_ff_bank.md
Name: jk_ff_bank

Overview:
Parametrised bank of WIDTH edge-triggered JK flip-flops sharing one clock. It is the clocked successor of the single-bit level-sensitive JK latch. Each bit supports hold, reset, set and toggle under per-bit enable. Two extra mode settings turn the bank into a synchronous up or down counter built from JK toggle semantics, for use as a small general-purpose state or count register in sequential-circuit exercises.

Parameters:
WIDTH, 8, number of JK flip-flops (channels); legal range 1..32
RST_VAL, {WIDTH{1'b0}}, value loaded into q on reset

Ports:
clk  input  1  clock; all state updates on the rising edge
rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk
en  input  1  global clock enable; 0 = whole bank holds, including flags
mode  input  2  00 = JK, 01 = parallel load, 10 = count up, 11 = count down
bit_en  input  WIDTH  per-bit enable; used in modes 00 and 01 only
j  input  WIDTH  per-bit J inputs (mode 00)
k  input  WIDTH  per-bit K inputs (mode 00)
d  input  WIDTH  parallel load data (mode 01)
q  output  WIDTH  flip-flop state (registered)
qb  output  WIDTH  always ~q (combinational from q)
changed  output  WIDTH  registered; bit i = 1 for one cycle after any edge where q[i] changed
wrap  output  1  registered; 1 for one cycle after a count-mode edge that wrapped (all-1 to 0 up, 0 to all-1 down)

Behaviour:
- Reset: rst = 0 at a rising edge gives q = RST_VAL, changed = 0, wrap = 0. qb = ~RST_VAL. Reset has priority over en and mode, and it aborts any count in progress with no partial update.
- en = 0 (rst = 1): q holds. changed and wrap are forced to 0 on that edge.
- Mode 00 (JK), per bit i with bit_en[i] = 1:
  - j = 0, k = 0: hold
  - j = 0, k = 1: q = 0
  - j = 1, k = 0: q = 1
  - j = 1, k = 1: q = ~q
  - bit_en[i] = 0: hold
  - wrap = 0.
- Mode 01 (load): q[i] = d[i] where bit_en[i] = 1; other bits hold. wrap = 0.
- Mode 10 (count up): q = q + 1 mod 2^WIDTH. bit_en, j, k and d are ignored. Implement as JK toggles: bit i toggles when bits 0..i-1 are all 1.
  - wrap = 1 on the edge where q goes from all-1 to 0.
- Mode 11 (count down): q = q - 1 mod 2^WIDTH. Bit i toggles when bits 0..i-1 are all 0.
  - wrap = 1 on the edge where q goes from 0 to all-1.
- changed = old_q ^ new_q, registered on the same edge as q. It is valid in every mode.
- Latency: one clock from sampled inputs to q, changed and wrap. There is no combinational path from j, k, d, mode, bit_en or en to any output.
- Mode change between consecutive cycles takes effect on the next edge with no bubble. Counting continues from the current q, whatever mode produced it.
- WIDTH = 1: count up and count down both toggle; wrap is asserted on every count edge.
- X or Z on inputs is not specified behaviour; inputs are driven known when rst = 1.

Test Plan:
- Reset: WIDTH = 8, RST_VAL = 8'hA5, rst = 0 for 2 edges while mode = 10 and en = 1 -> q = 8'hA5, qb = 8'h5A, changed = 0, wrap = 0. Then rst = 0 asserted mid-count from q = 8'h03 -> q = 8'hA5 on that edge.
- JK truth table: from q = 8'h00 with bit_en = 8'hFF:
  - j = 8'hF0, k = 8'h0C -> q = 8'hF0, changed = 8'hF0
  - then j = k = 8'hFF -> q = 8'h0F, changed = 8'hFF
  - then j = k = 0 -> q = 8'h0F, changed = 8'h00
- Per-bit enable: q = 8'h0F, mode 00, j = k = 8'hFF, bit_en = 8'h81 -> q = 8'h8E. Mode 01 with d = 8'h55 and bit_en = 8'hF0 -> q = 8'h5E.
- Count up wrap: load 8'hFE, mode 10 for 3 edges -> q sequence 8'hFF, 8'h00, 8'h01. wrap = 1 only after the FF-to-00 edge. changed = 8'hFF on that edge.
- Count down wrap plus enable: load 8'h01, mode 11 for 2 edges -> q = 8'h00, then 8'hFF with wrap = 1. Then en = 0 for 3 edges -> q stays 8'hFF, changed = 0, wrap = 0.
- Parameter sweep: WIDTH = 1 and WIDTH = 32. Count up from the all-1 value -> q = 0 with wrap = 1. WIDTH = 1 toggles on each count edge.
